// File: rtl/fp16_to_fp8_packer_if.sv
// Handshake bundle between the FP16 producer, the FP8 packer and the byte consumer.
// The packer uses the slave view; the producer/consumer side uses the master view.
interface fp16_to_fp8_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp16_to_fp8_packer.sv
// Converts FP16 words to saturating E4M3 bytes with round-to-nearest-even and
// buffers them in a small FIFO with sticky saturation/NaN flags.
module fp16_to_fp8_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    fp16_to_fp8_packer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_sat_flag,
    output logic                     o_nan_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_sat_flag;
    logic          r_nan_flag;
    logic [7:0]    r_last;
    logic [7:0]    r_mem [DEPTH];

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;

    logic          w_sign;
    logic [4:0]    w_exp;
    logic [9:0]    w_man;

    logic [3:0]    w_e8;
    logic          w_norm_up;
    logic [7:0]    w_norm_sum;

    logic [3:0]    w_sh;
    logic [15:0]   w_sig;
    logic [3:0]    w_frac;
    logic          w_sub_guard;
    logic [15:0]   w_sub_mask;
    logic          w_sub_sticky;
    logic          w_sub_up;
    logic [3:0]    w_sub_val;

    logic [7:0]    w_conv_byte;
    logic          w_conv_sat;
    logic          w_conv_nan;

    assign w_sign = bus.in_data[15];
    assign w_exp  = bus.in_data[14:10];
    assign w_man  = bus.in_data[9:0];

    // Normal target range: drop 7 mantissa bits, RNE on guard/sticky/lsb, carry ripples into exponent.
    assign w_e8       = 4'(w_exp - 5'd8);
    assign w_norm_up  = w_man[6] & ((|w_man[5:0]) | w_man[7]);
    assign w_norm_sum = {1'b0, w_e8, w_man[9:7]} + {7'd0, w_norm_up};

    // Subnormal target: denormalise the 11-bit significand by 16 - e16 (8..15), then RNE.
    assign w_sh         = 4'(5'd16 - w_exp);
    assign w_sig        = {5'd0, 1'b1, w_man};
    assign w_frac       = 4'(w_sig >> w_sh);
    assign w_sub_guard  = w_sig[w_sh - 4'd1];
    assign w_sub_mask   = (16'd1 << (w_sh - 4'd1)) - 16'd1;
    assign w_sub_sticky = |(w_sig & w_sub_mask);
    assign w_sub_up     = w_sub_guard & (w_sub_sticky | w_frac[0]);
    assign w_sub_val    = w_frac + {3'd0, w_sub_up};

    always_comb begin
        w_conv_byte = 8'h00;
        w_conv_sat  = 1'b0;
        w_conv_nan  = 1'b0;
        if (w_exp == 5'd31) begin
            if (w_man != 10'd0) begin
                w_conv_byte = {w_sign, 7'h7F};
                w_conv_nan  = 1'b1;
            end else begin
                w_conv_byte = {w_sign, 7'h7E};
                w_conv_sat  = 1'b1;
            end
        end else if (w_exp == 5'd0) begin
            w_conv_byte = {w_sign, 7'h00};
        end else if (w_exp >= 5'd24) begin
            w_conv_byte = {w_sign, 7'h7E};
            w_conv_sat  = 1'b1;
        end else if (w_exp >= 5'd9) begin
            // Rounding into the NaN code or past exponent 15 both clamp to max finite.
            if (w_norm_sum[7] || (w_norm_sum[6:0] == 7'h7F)) begin
                w_conv_byte = {w_sign, 7'h7E};
                w_conv_sat  = 1'b1;
            end else begin
                w_conv_byte = {w_sign, w_norm_sum[6:0]};
            end
        end else begin
            w_conv_byte = {w_sign, 3'b000, w_sub_val};
        end
    end

    assign w_in_ready  = (r_count < FULL_COUNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready & ~i_clear;
    assign w_pop       = w_out_valid & bus.out_ready & ~i_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_conv_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sat_flag <= 1'b0;
            r_nan_flag <= 1'b0;
            r_last     <= 8'h00;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sat_flag <= 1'b0;
            r_nan_flag <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + ONE_PTR;
                r_sat_flag <= r_sat_flag | w_conv_sat;
                r_nan_flag <= r_nan_flag | w_conv_nan;
            end
            // r_last lets out_data hold the most recently popped byte once the FIFO runs dry.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : r_last;
    assign o_count       = r_count;
    assign o_sat_flag    = r_sat_flag;
    assign o_nan_flag    = r_nan_flag;
endmodule
